// File: rtl/alu_share_arbiter.sv
// Shares one ALU between port A (EX stage) and port B (branch/address helper).
// Round-robin arbitration with an optional grant lock; registered result one cycle after acceptance.
module alu_share_arbiter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic             a_lock,
   input  logic [3:0]       a_op,
   input  logic [WIDTH-1:0] a_in1,
   input  logic [WIDTH-1:0] a_in2,
   output logic             a_ready,
   output logic             a_resp_valid,
   input  logic             b_valid,
   input  logic             b_lock,
   input  logic [3:0]       b_op,
   input  logic [WIDTH-1:0] b_in1,
   input  logic [WIDTH-1:0] b_in2,
   output logic             b_ready,
   output logic             b_resp_valid,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero
);

   localparam int unsigned CW = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {FREE, LOCK_A, LOCK_B} state_t;

   state_t          state, state_next;
   logic            last_b;
   logic [CW-1:0]   idle_cnt, idle_next;
   logic            acc_a, acc_b;
   logic [3:0]      op;
   logic [WIDTH-1:0] in1, in2, alu_res;

   assign acc_a = a_ready & a_valid;
   assign acc_b = b_ready & b_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FREE;
         last_b   <= 1'b1;
         idle_cnt <= '0;
      end else begin
         state    <= state_next;
         idle_cnt <= idle_next;
         if (acc_a)
            last_b <= 1'b0;
         else if (acc_b)
            last_b <= 1'b1;
      end
   end

   // In a locked state no acceptance implies the owner is idle this cycle
   always_comb begin
      state_next = state;
      idle_next  = '0;
      if (acc_a)
         state_next = a_lock ? LOCK_A : FREE;
      else if (acc_b)
         state_next = b_lock ? LOCK_B : FREE;
      else if (state != FREE) begin
         if (idle_cnt == CW'(LOCK_MAX - 1))
            state_next = FREE;
         else
            idle_next = idle_cnt + 1'b1;
      end
   end

   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (!reset) begin
         case (state)
            FREE: begin
               if (a_valid && b_valid) begin
                  a_ready = last_b;
                  b_ready = !last_b;
               end else begin
                  a_ready = a_valid;
                  b_ready = b_valid;
               end
            end
            LOCK_A:  a_ready = a_valid;
            LOCK_B:  b_ready = b_valid;
            default: ;
         endcase
      end
   end

   assign op  = acc_b ? b_op  : a_op;
   assign in1 = acc_b ? b_in1 : a_in1;
   assign in2 = acc_b ? b_in2 : a_in2;

   always_comb begin
      case (op)
         4'b0000: alu_res = in1 & in2;
         4'b0001: alu_res = in1 | in2;
         4'b0010: alu_res = in1 + in2;
         4'b0110: alu_res = in1 - in2;
         4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_resp_valid <= 1'b0;
         b_resp_valid <= 1'b0;
         resp_result  <= '0;
         resp_zero    <= 1'b0;
      end else begin
         a_resp_valid <= acc_a;
         b_resp_valid <= acc_b;
         if (acc_a || acc_b) begin
            resp_result <= alu_res;
            resp_zero   <= (alu_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: ALU vector table, hand-written
// arbitration/lock/reset sequences, and randomized traffic against a reference model.
module tb_alu_share_arbiter;

   localparam int unsigned W  = 32;
   localparam int unsigned LM = 8;

   logic          clk, reset;
   logic          a_valid, a_lock, b_valid, b_lock;
   logic [3:0]    a_op, b_op;
   logic [W-1:0]  a_in1, a_in2, b_in1, b_in2;
   logic          a_ready, b_ready, a_resp_valid, b_resp_valid, resp_zero;
   logic [W-1:0]  resp_result;
   logic          a_ready1, b_ready1, a_resp_valid1, b_resp_valid1, resp_zero1;
   logic [W-1:0]  resp_result1;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.WIDTH(W), .LOCK_MAX(LM)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_lock(a_lock), .a_op(a_op), .a_in1(a_in1), .a_in2(a_in2),
      .a_ready(a_ready), .a_resp_valid(a_resp_valid),
      .b_valid(b_valid), .b_lock(b_lock), .b_op(b_op), .b_in1(b_in1), .b_in2(b_in2),
      .b_ready(b_ready), .b_resp_valid(b_resp_valid),
      .resp_result(resp_result), .resp_zero(resp_zero)
   );

   alu_share_arbiter #(.WIDTH(W), .LOCK_MAX(1)) dut1 (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_lock(a_lock), .a_op(a_op), .a_in1(a_in1), .a_in2(a_in2),
      .a_ready(a_ready1), .a_resp_valid(a_resp_valid1),
      .b_valid(b_valid), .b_lock(b_lock), .b_op(b_op), .b_in1(b_in1), .b_in2(b_in2),
      .b_ready(b_ready1), .b_resp_valid(b_resp_valid1),
      .resp_result(resp_result1), .resp_zero(resp_zero1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] in1;
      logic [W-1:0] in2;
      logic [W-1:0] res;
      logic         zero;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic al, input logic [3:0] ao,
                        input logic [W-1:0] a1, input logic [W-1:0] a2,
                        input logic bv, input logic bl, input logic [3:0] bo,
                        input logic [W-1:0] b1, input logic [W-1:0] b2);
      a_valid = av; a_lock = al; a_op = ao; a_in1 = a1; a_in2 = a2;
      b_valid = bv; b_lock = bl; b_op = bo; b_in1 = b1; b_in2 = b2;
   endtask

   task automatic rdy(input string name, input logic ea, input logic eb);
      @(negedge clk);
      chk({name, "_a_ready"}, a_ready, ea);
      chk({name, "_b_ready"}, b_ready, eb);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      reset = 1'b0;
   endtask

   function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      case (op)
         4'd0:    return x & y;
         4'd1:    return x | y;
         4'd2:    return x + y;
         4'd6:    return x - y;
         4'd7:    return (x < y) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic logic [W-1:0] rnd_operand();
      if ($urandom_range(3) == 0)
         return W'($urandom_range(3));
      return W'($urandom());
   endfunction

   // reference model state: owner/last 0=none 1=A 2=B
   int m_owner, m_last, m_idle, g, vprob;
   logic [W-1:0] e_res;
   logic e_zero, e_av, e_bv;
   logic [3:0] ops[7];

   initial begin
      vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
      vecs[1]  = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
      vecs[2]  = '{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
      vecs[3]  = '{4'b0010, 32'h7,         32'h8,         32'hF,         1'b0};
      vecs[4]  = '{4'b0110, 32'h5,         32'h3,         32'h2,         1'b0};
      vecs[5]  = '{4'b0110, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0};
      vecs[6]  = '{4'b0110, 32'h9,         32'h9,         32'h0,         1'b1};
      vecs[7]  = '{4'b0111, 32'h8000_0000, 32'h1,         32'h0,         1'b1};
      vecs[8]  = '{4'b0111, 32'h1,         32'h8000_0000, 32'h1,         1'b0};
      vecs[9]  = '{4'b1111, 32'h1,         32'h2,         32'h0,         1'b1};
      vecs[10] = '{4'b0011, 32'hFFFF,      32'hFFFF,      32'h0,         1'b1};
      vecs[11] = '{4'b0000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0,         1'b1};
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd15, 4'd3};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 2, 1, 1, 1, 0, 2, 1, 1);
      rdy("in_reset", 0, 0);
      step();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_result", resp_result, 0);
      chk("rst_zero", resp_zero, 0);
      chk("rst_a_resp", a_resp_valid, 0);
      chk("rst_b_resp", b_resp_valid, 0);

      // contention, no locks: A, B, A, B
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 4'b0110, 5, 3, 1, 0, 4'b0110, 3, 5);
         rdy("rr", (i % 2) == 0, (i % 2) == 1);
         step();
         chk("rr_a_resp", a_resp_valid, (i % 2) == 0);
         chk("rr_b_resp", b_resp_valid, (i % 2) == 1);
         chk("rr_result", resp_result, ((i % 2) == 0) ? 32'h2 : 32'hFFFF_FFFE);
      end

      // ALU table through port A
      for (int i = 0; i < 12; i++) begin
         drive(1, 0, vecs[i].op, vecs[i].in1, vecs[i].in2, 0, 0, 0, 0, 0);
         rdy("vec", 1, 0);
         step();
         chk("vec_a_resp", a_resp_valid, 1);
         chk("vec_b_resp", b_resp_valid, 0);
         chk("vec_result", resp_result, vecs[i].res);
         chk("vec_zero", resp_zero, vecs[i].zero);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("hold_result", resp_result, 32'h0);
      chk("hold_a_resp", a_resp_valid, 0);

      // A lock sequence 1,1,0 with B pending
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive(1, i < 2, 4'b0010, i, 10, 1, 0, 4'b0010, 100, 0);
         rdy("lock", 1, 0);
         step();
         chk("lock_a_resp", a_resp_valid, 1);
         chk("lock_result", resp_result, i + 10);
      end
      drive(0, 0, 0, 0, 0, 1, 0, 4'b0010, 100, 0);
      rdy("unlock", 0, 1);
      step();
      chk("unlock_b_resp", b_resp_valid, 1);
      chk("unlock_result", resp_result, 100);

      // idle timeout at LOCK_MAX = 8
      reset_dut();
      drive(1, 1, 4'b0001, 1, 2, 1, 0, 4'b0001, 4, 8);
      rdy("to_lock", 1, 0);
      step();
      for (int i = 0; i < int'(LM); i++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 4'b0001, 4, 8);
         rdy("to_idle", 0, 0);
         step();
      end
      rdy("to_release", 0, 1);
      step();
      chk("to_b_resp", b_resp_valid, 1);
      chk("to_result", resp_result, 12);

      // idle timeout at LOCK_MAX = 1
      reset_dut();
      drive(1, 1, 4'b0010, 1, 1, 1, 0, 4'b0010, 2, 2);
      @(negedge clk);
      chk("lm1_a_ready", a_ready1, 1);
      step();
      drive(0, 0, 0, 0, 0, 1, 0, 4'b0010, 2, 2);
      @(negedge clk);
      chk("lm1_idle_b_ready", b_ready1, 0);
      step();
      @(negedge clk);
      chk("lm1_release_b_ready", b_ready1, 1);
      step();
      chk("lm1_result", resp_result1, 4);

      // reset in the same cycle as an A request
      reset_dut();
      drive(1, 0, 4'b0010, 3, 4, 0, 0, 0, 0, 0);
      rdy("pre_rst", 1, 0);
      step();
      chk("pre_rst_result", resp_result, 7);
      reset = 1'b1;
      rdy("mid_rst", 0, 0);
      step();
      reset = 1'b0;
      chk("mid_rst_a_resp", a_resp_valid, 0);
      chk("mid_rst_result", resp_result, 0);
      chk("mid_rst_zero", resp_zero, 0);
      drive(1, 0, 4'b0010, 1, 1, 1, 0, 4'b0010, 5, 5);
      rdy("post_rst_tie", 1, 0);
      step();
      chk("post_rst_result", resp_result, 2);

      // randomized traffic against the reference model
      reset_dut();
      m_owner = 0; m_last = 2; m_idle = 0;
      e_res = '0; e_zero = 1'b0;
      vprob = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0)
            vprob = ($urandom_range(2) == 0) ? 15 : (($urandom_range(1) == 0) ? 50 : 90);
         reset = ($urandom_range(63) == 0);
         drive($urandom_range(99) < vprob, $urandom_range(2) == 0, ops[$urandom_range(6)],
               rnd_operand(), rnd_operand(),
               $urandom_range(99) < vprob, $urandom_range(2) == 0, ops[$urandom_range(6)],
               rnd_operand(), rnd_operand());
         g = 0;
         if (!reset) begin
            if (m_owner == 1)      g = a_valid ? 1 : 0;
            else if (m_owner == 2) g = b_valid ? 2 : 0;
            else if (a_valid && b_valid) g = (m_last == 2) ? 1 : 2;
            else if (a_valid)      g = 1;
            else if (b_valid)      g = 2;
         end
         rdy("rand", g == 1, g == 2);
         if (reset) begin
            m_owner = 0; m_last = 2; m_idle = 0;
            e_res = '0; e_zero = 1'b0; e_av = 1'b0; e_bv = 1'b0;
         end else begin
            e_av = (g == 1);
            e_bv = (g == 2);
            if (g != 0) begin
               m_last  = g;
               m_owner = ((g == 1) ? a_lock : b_lock) ? g : 0;
               m_idle  = 0;
               e_res   = (g == 1) ? ref_alu(a_op, a_in1, a_in2) : ref_alu(b_op, b_in1, b_in2);
               e_zero  = (e_res == 0);
            end else if (m_owner != 0) begin
               m_idle++;
               if (m_idle == int'(LM)) begin
                  m_owner = 0;
                  m_idle  = 0;
               end
            end
         end
         step();
         chk("rand_a_resp", a_resp_valid, e_av);
         chk("rand_b_resp", b_resp_valid, e_bv);
         chk("rand_result", resp_result, e_res);
         chk("rand_zero", resp_zero, e_zero);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
